mrv1_mul_fu_sched: RTL and testbench
====================================

Name: mrv1_mul_fu_sched

Overview:
- Sequences the shared, non-pipelined multiply/divide functional unit (mrv1_mul_fu) across all hardware threads of the multithreaded core.
- Arbitrates per-thread issue requests round-robin and holds one operation in flight at a time.
- Drives the FU req/rdy/done handshake and returns results to writeback through a one-entry result buffer with valid/ready.
- Supports per-thread flush (kill) at every stage.

Parameters:
- DATA_WIDTH_P, 32: operand and result width.
- ITAG_WIDTH_P, 3: instruction tag width.
- NUM_THREADS_P, 4: number of hardware threads; must be ≥2.
- TID_WIDTH_LP, $clog2(NUM_THREADS_P): thread id width (derived).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_THREADS_P  per-thread mul/div request.
- req_ready_o  out  NUM_THREADS_P  one-hot grant/accept.
- req_opc_i  in  NUM_THREADS_P x mrv_mul_fu_op_e  per-thread opcode.
- req_src0_i / req_src1_i / req_src2_i  in  NUM_THREADS_P x DATA_WIDTH_P  per-thread operands.
- req_itag_i  in  NUM_THREADS_P x ITAG_WIDTH_P  per-thread itag.
- flush_i  in  NUM_THREADS_P  per-thread kill.
- fu_req_o  out  1  request to FU.
- fu_rdy_i  in  1  FU accepts.
- fu_opc_o  out  mrv_mul_fu_op_e  opcode to FU.
- fu_src0_o / fu_src1_o / fu_src2_o  out  DATA_WIDTH_P  operands to FU.
- fu_itag_o  out  ITAG_WIDTH_P  itag to FU.
- fu_tid_o  out  TID_WIDTH_LP  tid to FU.
- fu_done_i  in  1  FU result valid.
- fu_res_i  in  DATA_WIDTH_P  FU result.
- fu_itag_i  in  ITAG_WIDTH_P  itag returned by FU.
- fu_tid_i  in  TID_WIDTH_LP  tid returned by FU.
- wb_valid_o  out  1  result valid to writeback.
- wb_ready_i  in  1  writeback accepts.
- wb_data_o  out  DATA_WIDTH_P  result.
- wb_itag_o  out  ITAG_WIDTH_P  itag of result.
- wb_tid_o  out  TID_WIDTH_LP  tid of result.
- busy_o  out  1  scheduler not IDLE.

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; all outputs 0; operand/tag/result registers 0; rr_ptr=NUM_THREADS_P-1 (thread 0 has first priority); kill=0. Reset mid-operation abandons the op silently; the FU is reset by the same rst_ni.
- IDLE:
  - eligible = req_valid_i & ~flush_i.
  - If any eligible, grant the first set bit at rr_ptr+1 upward, wrapping modulo NUM_THREADS_P.
  - req_ready_o is one-hot on the granted bit (combinational, this cycle only).
  - Latch opc, srcs, itag and tid; set rr_ptr=grant; go to ISSUE.
  - No eligible request: stay in IDLE, req_ready_o=0.
- ISSUE:
  - fu_req_o=1; fu_* outputs driven from the latched registers.
  - fu_req_o & fu_rdy_i -> WAIT, with kill = flush_i[tid].
  - flush_i[tid] without fu_rdy_i -> IDLE with no FU transfer.
  - Otherwise hold; operands stay stable while fu_req_o is high.
- WAIT:
  - fu_req_o=0; kill |= flush_i[tid].
  - On fu_done_i: if kill, or flush_i[tid] this cycle, go to IDLE and drop the result.
  - Otherwise capture fu_res_i into the result buffer and go to RESP.
- RESP:
  - wb_valid_o = ~flush_i[tid] (combinational mask), with buffered data and latched itag/tid.
  - wb_valid_o & wb_ready_i -> IDLE.
  - flush_i[tid] -> IDLE with no handshake.
  - Otherwise hold; data stable.
- Latency with immediate fu_rdy_i: accept at cycle 0, fu_req_o at cycle 1, FU done at cycle D, wb_valid_o at cycle D+1.
- No new grant until return to IDLE (single outstanding op); the next grant occurs the cycle after returning to IDLE.
- fu_done_i outside WAIT is ignored.
- In WAIT, a fu_done_i whose fu_tid_i/fu_itag_i mismatch the latched values is an error: simulation-only assertion; the latched values are used for wb.
- Simultaneous flush and handshake: flush wins in every state except ISSUE with fu_rdy_i high, where the transfer completes and the result is dropped later.
- busy_o = (state != IDLE).

Decomposition:
- mrv1_pkg holds:
  - mrv_mul_fu_op_e (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
  - MUL_FU_OP_WIDTH.
  - mrv1_mul_sched_state_e {IDLE, ISSUE, WAIT, RESP}.
- Sub-module mrv1_rr_arbiter (NUM_REQ_P): inputs req vector and last-grant pointer; output one-hot grant and encoded index. Purely combinational; the pointer register lives in the scheduler.

Test Plan:
- Single request: thread 2 requests MUL, src0=7, src1=6, itag=5; FU rdy=1, done 3 cycles later with res=42 -> wb_valid_o=1 at cycle 4 with data=42, itag=5, tid=2.
- Round-robin: all 4 threads request continuously, immediate FU and wb -> grant order 0,1,2,3,0; no thread granted twice before all others are served.
- Backpressure: fu_rdy_i low for 5 cycles, then wb_ready_i low for 3 cycles -> fu_* and wb_* outputs stable throughout; exactly one transfer of each; req_ready_o stays 0.
- Flush in WAIT: thread 1 op in flight, flush_i[1] pulsed, FU done with res=0xDEAD -> wb_valid_o never asserts; next request is granted the cycle after done.
- Flush vs. accept race: flush_i[tid] and fu_rdy_i high in the same ISSUE cycle -> WAIT entered, result dropped on done; flush in ISSUE without rdy -> fu_req_o drops next cycle, no FU transfer.
- Async reset: rst_ni low during WAIT -> wb_valid_o, fu_req_o and busy_o go 0 immediately; after release, thread 0 wins the first arbitration.

Source files
------------

// File: rtl/mrv1_pkg.sv
// Shared types for the mrv1 multiply/divide scheduling slice.
package mrv1_pkg;

   localparam int MUL_FU_OP_WIDTH = 3;

   typedef enum logic [MUL_FU_OP_WIDTH-1:0] {
      MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
   } mrv_mul_fu_op_e;

   typedef enum logic [1:0] {
      IDLE, ISSUE, WAIT, RESP
   } mrv1_mul_sched_state_e;

endpackage

// File: rtl/mrv1_rr_arbiter.sv
// Combinational round-robin arbiter: zero latency, no backpressure of its own.
// Searches upward from last_i+1 with wrap; the pointer register belongs to the caller.
module mrv1_rr_arbiter #(
   parameter int NUM_REQ_P = 4,
   localparam int IDX_W_LP = $clog2(NUM_REQ_P)
) (
   input  logic [NUM_REQ_P-1:0] req_i,
   input  logic [IDX_W_LP-1:0]  last_i,
   output logic [NUM_REQ_P-1:0] gnt_o,
   output logic [IDX_W_LP-1:0]  idx_o
);

   logic [IDX_W_LP-1:0] cand;
   logic                found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      // Offset 1..N visits last_i+1 first and last_i itself last.
      for (int i = 1; i <= NUM_REQ_P; i++) begin
         cand = IDX_W_LP'((int'(last_i) + i) % NUM_REQ_P);
         if (!found && req_i[cand]) begin
            found        = 1'b1;
            idx_o        = cand;
            gnt_o[cand]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mrv1_mul_fu_sched.sv
// Round-robin scheduler for the shared non-pipelined mul/div FU, one op in flight.
// Grant at cycle 0, FU request at 1, writeback the cycle after FU done; holds on fu_rdy_i / wb_ready_i low.
module mrv1_mul_fu_sched
   import mrv1_pkg::*;
#(
   parameter int DATA_WIDTH_P  = 32,
   parameter int ITAG_WIDTH_P  = 3,
   parameter int NUM_THREADS_P = 4,
   localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic [NUM_THREADS_P-1:0]                    req_valid_i,
   output logic [NUM_THREADS_P-1:0]                    req_ready_o,
   input  mrv_mul_fu_op_e [NUM_THREADS_P-1:0]          req_opc_i,
   input  logic [NUM_THREADS_P-1:0][DATA_WIDTH_P-1:0]  req_src0_i,
   input  logic [NUM_THREADS_P-1:0][DATA_WIDTH_P-1:0]  req_src1_i,
   input  logic [NUM_THREADS_P-1:0][DATA_WIDTH_P-1:0]  req_src2_i,
   input  logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]  req_itag_i,
   input  logic [NUM_THREADS_P-1:0]                    flush_i,
   output logic                                        fu_req_o,
   input  logic                                        fu_rdy_i,
   output mrv_mul_fu_op_e                              fu_opc_o,
   output logic [DATA_WIDTH_P-1:0]                     fu_src0_o,
   output logic [DATA_WIDTH_P-1:0]                     fu_src1_o,
   output logic [DATA_WIDTH_P-1:0]                     fu_src2_o,
   output logic [ITAG_WIDTH_P-1:0]                     fu_itag_o,
   output logic [TID_WIDTH_LP-1:0]                     fu_tid_o,
   input  logic                                        fu_done_i,
   input  logic [DATA_WIDTH_P-1:0]                     fu_res_i,
   input  logic [ITAG_WIDTH_P-1:0]                     fu_itag_i,
   input  logic [TID_WIDTH_LP-1:0]                     fu_tid_i,
   output logic                                        wb_valid_o,
   input  logic                                        wb_ready_i,
   output logic [DATA_WIDTH_P-1:0]                     wb_data_o,
   output logic [ITAG_WIDTH_P-1:0]                     wb_itag_o,
   output logic [TID_WIDTH_LP-1:0]                     wb_tid_o,
   output logic                                        busy_o
);

   typedef struct packed {
      mrv_mul_fu_op_e            opc;
      logic [DATA_WIDTH_P-1:0]   src0;
      logic [DATA_WIDTH_P-1:0]   src1;
      logic [DATA_WIDTH_P-1:0]   src2;
      logic [ITAG_WIDTH_P-1:0]   itag;
   } op_t;

   mrv1_mul_sched_state_e        state_q;
   op_t                          op_q;
   logic [TID_WIDTH_LP-1:0]      tid_q;
   logic [TID_WIDTH_LP-1:0]      rr_ptr_q;
   logic [DATA_WIDTH_P-1:0]      res_q;
   logic                         kill_q;

   logic [NUM_THREADS_P-1:0]     eligible;
   logic [NUM_THREADS_P-1:0]     grant;
   logic [TID_WIDTH_LP-1:0]      grant_idx;
   logic                         grant_vld;
   logic                         flush_cur;

   assign eligible  = req_valid_i & ~flush_i;
   assign grant_vld = |grant;
   assign flush_cur = flush_i[tid_q];

   mrv1_rr_arbiter #(
      .NUM_REQ_P (NUM_THREADS_P)
   ) u_arb (
      .req_i  (eligible),
      .last_i (rr_ptr_q),
      .gnt_o  (grant),
      .idx_o  (grant_idx)
   );

   // Gated by rst_ni so no grant is advertised while the scheduler is held in reset.
   assign req_ready_o = (state_q == IDLE && rst_ni) ? grant : '0;

   assign fu_req_o   = (state_q == ISSUE);
   assign fu_opc_o   = op_q.opc;
   assign fu_src0_o  = op_q.src0;
   assign fu_src1_o  = op_q.src1;
   assign fu_src2_o  = op_q.src2;
   assign fu_itag_o  = op_q.itag;
   assign fu_tid_o   = tid_q;

   assign wb_valid_o = (state_q == RESP) && !flush_cur;
   assign wb_data_o  = res_q;
   assign wb_itag_o  = op_q.itag;
   assign wb_tid_o   = tid_q;

   assign busy_o     = (state_q != IDLE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         op_q     <= '0;
         tid_q    <= '0;
         rr_ptr_q <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
         res_q    <= '0;
         kill_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_vld) begin
                  op_q.opc  <= req_opc_i[grant_idx];
                  op_q.src0 <= req_src0_i[grant_idx];
                  op_q.src1 <= req_src1_i[grant_idx];
                  op_q.src2 <= req_src2_i[grant_idx];
                  op_q.itag <= req_itag_i[grant_idx];
                  tid_q     <= grant_idx;
                  rr_ptr_q  <= grant_idx;
                  kill_q    <= 1'b0;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               // A completed transfer cannot be recalled; a racing flush is remembered instead.
               if (fu_rdy_i) begin
                  kill_q  <= flush_cur;
                  state_q <= WAIT;
               end else if (flush_cur) begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               kill_q <= kill_q | flush_cur;
               if (fu_done_i) begin
                  if (kill_q || flush_cur) begin
                     state_q <= IDLE;
                  end else begin
                     res_q   <= fu_res_i;
                     state_q <= RESP;
                  end
               end
            end
            RESP: begin
               if (flush_cur || wb_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   a_done_tag_match: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      (state_q == WAIT && fu_done_i) |-> (fu_tid_i == tid_q && fu_itag_i == op_q.itag)
   );

endmodule

// File: tb/tb_mrv1_mul_fu_sched.sv
// Directed bench for the mul/div FU scheduler: arbitration, handshakes, flush and reset.
module tb_mrv1_mul_fu_sched;
   import mrv1_pkg::*;

   localparam int DW = 32;
   localparam int IW = 3;
   localparam int NT = 4;
   localparam int TW = 2;

   logic                     clk_i = 1'b0;
   logic                     rst_ni = 1'b0;
   logic [NT-1:0]            req_valid_i;
   logic [NT-1:0]            req_ready_o;
   mrv_mul_fu_op_e [NT-1:0]  req_opc_i;
   logic [NT-1:0][DW-1:0]    req_src0_i;
   logic [NT-1:0][DW-1:0]    req_src1_i;
   logic [NT-1:0][DW-1:0]    req_src2_i;
   logic [NT-1:0][IW-1:0]    req_itag_i;
   logic [NT-1:0]            flush_i;
   logic                     fu_req_o;
   logic                     fu_rdy_i;
   mrv_mul_fu_op_e           fu_opc_o;
   logic [DW-1:0]            fu_src0_o, fu_src1_o, fu_src2_o;
   logic [IW-1:0]            fu_itag_o;
   logic [TW-1:0]            fu_tid_o;
   logic                     fu_done_i;
   logic [DW-1:0]            fu_res_i;
   logic [IW-1:0]            fu_itag_i;
   logic [TW-1:0]            fu_tid_i;
   logic                     wb_valid_o;
   logic                     wb_ready_i;
   logic [DW-1:0]            wb_data_o;
   logic [IW-1:0]            wb_itag_o;
   logic [TW-1:0]            wb_tid_o;
   logic                     busy_o;

   int n_checks = 0;
   int n_pass   = 0;

   logic          fm_done_next;
   logic [TW-1:0] fm_tid;
   logic [IW-1:0] fm_itag;

   always #5 clk_i = ~clk_i;

   mrv1_mul_fu_sched #(
      .DATA_WIDTH_P  (DW),
      .ITAG_WIDTH_P  (IW),
      .NUM_THREADS_P (NT)
   ) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_opc_i   (req_opc_i),
      .req_src0_i  (req_src0_i),
      .req_src1_i  (req_src1_i),
      .req_src2_i  (req_src2_i),
      .req_itag_i  (req_itag_i),
      .flush_i     (flush_i),
      .fu_req_o    (fu_req_o),
      .fu_rdy_i    (fu_rdy_i),
      .fu_opc_o    (fu_opc_o),
      .fu_src0_o   (fu_src0_o),
      .fu_src1_o   (fu_src1_o),
      .fu_src2_o   (fu_src2_o),
      .fu_itag_o   (fu_itag_o),
      .fu_tid_o    (fu_tid_o),
      .fu_done_i   (fu_done_i),
      .fu_res_i    (fu_res_i),
      .fu_itag_i   (fu_itag_i),
      .fu_tid_i    (fu_tid_i),
      .wb_valid_o  (wb_valid_o),
      .wb_ready_i  (wb_ready_i),
      .wb_data_o   (wb_data_o),
      .wb_itag_o   (wb_itag_o),
      .wb_tid_o    (wb_tid_o),
      .busy_o      (busy_o)
   );

   task automatic idle_inputs();
      req_valid_i = '0;
      flush_i     = '0;
      fu_rdy_i    = 1'b0;
      fu_done_i   = 1'b0;
      fu_res_i    = '0;
      fu_itag_i   = '0;
      fu_tid_i    = '0;
      wb_ready_i  = 1'b1;
   endtask

   // Behavioural FU: accepts immediately, finishes one cycle later with result 100+tid.
   task automatic fu_cycle();
      fu_done_i = fm_done_next;
      fu_tid_i  = fm_tid;
      fu_itag_i = fm_itag;
      fu_res_i  = DW'(100 + int'(fm_tid));
      #1;
      fm_done_next = fu_req_o & fu_rdy_i;
      fm_tid       = fu_tid_o;
      fm_itag      = fu_itag_o;
   endtask

   task automatic test_reset();
      idle_inputs();
      req_valid_i = '1;
      rst_ni      = 1'b0;
      for (int i = 0; i < NT; i++) begin
         req_opc_i[i]  = MUL;
         req_src0_i[i] = DW'(i + 1);
         req_src1_i[i] = DW'(i + 2);
         req_src2_i[i] = '0;
         req_itag_i[i] = IW'(i + 1);
      end
      fm_done_next = 1'b0;
      fm_tid       = '0;
      fm_itag      = '0;
      repeat (3) @(negedge clk_i);
      #1;
      n_checks++; if (req_ready_o !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready_o); else n_pass++;
      n_checks++; if (fu_req_o !== 1'b0) $display("FAIL reset_fu_req: got %b want 0", fu_req_o); else n_pass++;
      n_checks++; if (wb_valid_o !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
      n_checks++; if (fu_src0_o !== 32'd0 || fu_tid_o !== 2'd0 || wb_data_o !== 32'd0) $display("FAIL reset_regs: src0=%h tid=%0d wb_data=%h want all 0", fu_src0_o, fu_tid_o, wb_data_o); else n_pass++;
      @(negedge clk_i);
      rst_ni      = 1'b1;
      req_valid_i = '0;
   endtask

   task automatic test_round_robin();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int got;
      int wbn;
      logic drained;
      got = 0;
      wbn = 0;
      drained = 1'b0;
      req_valid_i = '1;
      fu_rdy_i    = 1'b1;
      wb_ready_i  = 1'b1;
      for (int c = 0; c < 60 && got < 5; c++) begin
         fu_cycle();
         if (req_ready_o != '0) begin
            n_checks++;
            if (req_ready_o !== (4'b0001 << exp_order[got])) $display("FAIL rr_grant%0d: got %b want thread %0d", got, req_ready_o, exp_order[got]);
            else n_pass++;
            got++;
         end
         if (wb_valid_o && wbn < 4) begin
            n_checks++;
            if (wb_tid_o !== TW'(exp_order[wbn]) || wb_data_o !== DW'(100 + exp_order[wbn]))
               $display("FAIL rr_wb%0d: tid=%0d data=%0d want tid=%0d data=%0d", wbn, wb_tid_o, wb_data_o, exp_order[wbn], 100 + exp_order[wbn]);
            else n_pass++;
            wbn++;
         end
         @(negedge clk_i);
      end
      n_checks++; if (got !== 5) $display("FAIL rr_grant_count: got %0d grants want 5 within budget", got); else n_pass++;
      n_checks++; if (wbn !== 4) $display("FAIL rr_wb_count: got %0d writebacks want 4", wbn); else n_pass++;
      req_valid_i = '0;
      for (int c = 0; c < 20 && !drained; c++) begin
         fu_cycle();
         drained = !busy_o;
         @(negedge clk_i);
      end
      n_checks++; if (drained !== 1'b1) $display("FAIL rr_drain: busy_o still %b want 0", busy_o); else n_pass++;
      fm_done_next = 1'b0;
      idle_inputs();
   endtask

   task automatic test_single();
      req_valid_i   = 4'b0100;
      req_opc_i[2]  = MUL;
      req_src0_i[2] = 32'd7;
      req_src1_i[2] = 32'd6;
      req_src2_i[2] = 32'd0;
      req_itag_i[2] = 3'd5;
      #1;
      n_checks++; if (req_ready_o !== 4'b0100) $display("FAIL single_grant: got %b want 0100", req_ready_o); else n_pass++;
      @(negedge clk_i);
      req_valid_i = '0;
      fu_rdy_i    = 1'b1;
      #1;
      n_checks++; if (fu_req_o !== 1'b1 || busy_o !== 1'b1) $display("FAIL single_fu_req: fu_req=%b busy=%b want 1 1", fu_req_o, busy_o); else n_pass++;
      n_checks++; if (fu_opc_o !== MUL || fu_src0_o !== 32'd7 || fu_src1_o !== 32'd6) $display("FAIL single_fu_ops: opc=%0d src0=%0d src1=%0d want 0 7 6", fu_opc_o, fu_src0_o, fu_src1_o); else n_pass++;
      n_checks++; if (fu_itag_o !== 3'd5 || fu_tid_o !== 2'd2) $display("FAIL single_fu_tags: itag=%0d tid=%0d want 5 2", fu_itag_o, fu_tid_o); else n_pass++;
      @(negedge clk_i);
      fu_rdy_i = 1'b0;
      #1;
      n_checks++; if (fu_req_o !== 1'b0) $display("FAIL single_wait_req: got %b want 0", fu_req_o); else n_pass++;
      @(negedge clk_i);
      fu_done_i = 1'b1;
      fu_res_i  = 32'd42;
      fu_tid_i  = 2'd2;
      fu_itag_i = 3'd5;
      #1;
      n_checks++; if (wb_valid_o !== 1'b0) $display("FAIL single_wb_early: got %b want 0", wb_valid_o); else n_pass++;
      @(negedge clk_i);
      fu_done_i = 1'b0;
      #1;
      n_checks++; if (wb_valid_o !== 1'b1) $display("FAIL single_wb_valid: got %b want 1 at cycle 4", wb_valid_o); else n_pass++;
      n_checks++; if (wb_data_o !== 32'd42 || wb_itag_o !== 3'd5 || wb_tid_o !== 2'd2) $display("FAIL single_wb_data: data=%0d itag=%0d tid=%0d want 42 5 2", wb_data_o, wb_itag_o, wb_tid_o); else n_pass++;
      @(negedge clk_i);
      #1;
      n_checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) $display("FAIL single_done: busy=%b wb_valid=%b want 0 0", busy_o, wb_valid_o); else n_pass++;
      @(negedge clk_i);
   endtask

   task automatic test_backpressure();
      int bad;
      int fu_xfers;
      int wb_xfers;
      int grants;
      bad = 0; fu_xfers = 0; wb_xfers = 0; grants = 0;
      req_valid_i   = 4'b0010;
      req_opc_i[1]  = DIV;
      req_src0_i[1] = 32'd100;
      req_src1_i[1] = 32'd7;
      req_src2_i[1] = 32'd9;
      req_itag_i[1] = 3'd3;
      fu_rdy_i      = 1'b0;
      wb_ready_i    = 1'b0;
      #1;
      n_checks++; if (req_ready_o !== 4'b0010) $display("FAIL bp_grant: got %b want 0010", req_ready_o); else n_pass++;
      @(negedge clk_i);
      for (int c = 1; c <= 12; c++) begin
         req_valid_i = (c == 12) ? 4'b0000 : 4'b1111;
         fu_rdy_i    = (c == 6);
         fu_done_i   = (c == 8);
         fu_res_i    = 32'h1234;
         fu_tid_i    = 2'd1;
         fu_itag_i   = 3'd3;
         wb_ready_i  = (c == 12);
         #1;
         if (req_ready_o !== 4'b0000) grants++;
         if (fu_req_o && fu_rdy_i) fu_xfers++;
         if (wb_valid_o && wb_ready_i) wb_xfers++;
         if (c <= 6) begin
            if (fu_req_o !== 1'b1 || fu_opc_o !== DIV || fu_src0_o !== 32'd100 || fu_src1_o !== 32'd7 ||
                fu_src2_o !== 32'd9 || fu_itag_o !== 3'd3 || fu_tid_o !== 2'd1 || wb_valid_o !== 1'b0) bad++;
         end else if (c <= 8) begin
            if (fu_req_o !== 1'b0 || wb_valid_o !== 1'b0) bad++;
         end else begin
            if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h1234 || wb_itag_o !== 3'd3 ||
                wb_tid_o !== 2'd1 || fu_req_o !== 1'b0) bad++;
         end
         @(negedge clk_i);
      end
      n_checks++; if (bad !== 0) $display("FAIL bp_stable: %0d unstable cycles want 0", bad); else n_pass++;
      n_checks++; if (fu_xfers !== 1) $display("FAIL bp_fu_xfers: got %0d want 1", fu_xfers); else n_pass++;
      n_checks++; if (wb_xfers !== 1) $display("FAIL bp_wb_xfers: got %0d want 1", wb_xfers); else n_pass++;
      n_checks++; if (grants !== 0) $display("FAIL bp_no_grant: %0d cycles with req_ready_o set want 0", grants); else n_pass++;
      idle_inputs();
      #1;
      n_checks++; if (busy_o !== 1'b0 || wb_valid_o !== 1'b0) $display("FAIL bp_idle: busy=%b wb_valid=%b want 0 0", busy_o, wb_valid_o); else n_pass++;
      @(negedge clk_i);
   endtask

   task automatic test_flush_wait();
      int wb_seen;
      wb_seen = 0;
      req_valid_i   = 4'b0010;
      req_itag_i[1] = 3'd2;
      #1;
      n_checks++; if (req_ready_o !== 4'b0010) $display("FAIL fw_grant: got %b want 0010", req_ready_o); else n_pass++;
      @(negedge clk_i);
      req_valid_i = '0;
      fu_rdy_i    = 1'b1;
      @(negedge clk_i);
      fu_rdy_i = 1'b0;
      flush_i  = 4'b0010;
      #1;
      if (wb_valid_o) wb_seen++;
      @(negedge clk_i);
      flush_i     = '0;
      fu_done_i   = 1'b1;
      fu_res_i    = 32'hDEAD;
      fu_tid_i    = 2'd1;
      fu_itag_i   = 3'd2;
      req_valid_i = 4'b1000;
      #1;
      n_checks++; if (req_ready_o !== 4'b0000) $display("FAIL fw_no_early_grant: got %b want 0000", req_ready_o); else n_pass++;
      if (wb_valid_o) wb_seen++;
      @(negedge clk_i);
      fu_done_i = 1'b0;
      #1;
      if (wb_valid_o) wb_seen++;
      n_checks++; if (req_ready_o !== 4'b1000) $display("FAIL fw_next_grant: got %b want 1000", req_ready_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL fw_idle: busy=%b want 0", busy_o); else n_pass++;
      @(negedge clk_i);
      req_valid_i = '0;
      flush_i     = 4'b1000;
      #1;
      if (wb_valid_o) wb_seen++;
      n_checks++; if (fu_req_o !== 1'b1 || fu_tid_o !== 2'd3) $display("FAIL fi_issue: fu_req=%b tid=%0d want 1 3", fu_req_o, fu_tid_o); else n_pass++;
      @(negedge clk_i);
      flush_i = '0;
      #1;
      n_checks++; if (fu_req_o !== 1'b0 || busy_o !== 1'b0) $display("FAIL fi_drop: fu_req=%b busy=%b want 0 0", fu_req_o, busy_o); else n_pass++;
      n_checks++; if (wb_seen !== 0) $display("FAIL fw_no_wb: wb_valid seen %0d cycles want 0", wb_seen); else n_pass++;
      @(negedge clk_i);
   endtask

   task automatic test_flush_race();
      int wb_seen;
      wb_seen = 0;
      req_valid_i   = 4'b0100;
      req_itag_i[2] = 3'd6;
      #1;
      n_checks++; if (req_ready_o !== 4'b0100) $display("FAIL race_grant: got %b want 0100", req_ready_o); else n_pass++;
      @(negedge clk_i);
      req_valid_i = '0;
      fu_rdy_i    = 1'b1;
      flush_i     = 4'b0100;
      #1;
      n_checks++; if (fu_req_o !== 1'b1) $display("FAIL race_xfer: fu_req=%b want 1", fu_req_o); else n_pass++;
      @(negedge clk_i);
      fu_rdy_i = 1'b0;
      flush_i  = '0;
      #1;
      n_checks++; if (busy_o !== 1'b1 || fu_req_o !== 1'b0) $display("FAIL race_wait: busy=%b fu_req=%b want 1 0", busy_o, fu_req_o); else n_pass++;
      @(negedge clk_i);
      fu_done_i = 1'b1;
      fu_res_i  = 32'h55;
      fu_tid_i  = 2'd2;
      fu_itag_i = 3'd6;
      #1;
      if (wb_valid_o) wb_seen++;
      @(negedge clk_i);
      fu_done_i = 1'b0;
      #1;
      if (wb_valid_o) wb_seen++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL race_idle: busy=%b want 0", busy_o); else n_pass++;
      n_checks++; if (wb_seen !== 0) $display("FAIL race_no_wb: wb_valid seen %0d cycles want 0", wb_seen); else n_pass++;
      @(negedge clk_i);
   endtask

   task automatic test_async_reset();
      req_valid_i = 4'b1000;
      @(negedge clk_i);
      req_valid_i = '0;
      fu_rdy_i    = 1'b1;
      @(negedge clk_i);
      fu_rdy_i = 1'b0;
      #1;
      n_checks++; if (busy_o !== 1'b1) $display("FAIL arst_pre_busy: got %b want 1", busy_o); else n_pass++;
      #2;
      rst_ni = 1'b0;
      #1;
      n_checks++; if (busy_o !== 1'b0 || fu_req_o !== 1'b0 || wb_valid_o !== 1'b0) $display("FAIL arst_immediate: busy=%b fu_req=%b wb_valid=%b want 0 0 0", busy_o, fu_req_o, wb_valid_o); else n_pass++;
      @(negedge clk_i);
      rst_ni      = 1'b1;
      req_valid_i = 4'b1111;
      #1;
      n_checks++; if (req_ready_o !== 4'b0001) $display("FAIL arst_first_grant: got %b want 0001", req_ready_o); else n_pass++;
      @(negedge clk_i);
      req_valid_i = '0;
      flush_i     = 4'b0001;
      #1;
      n_checks++; if (fu_req_o !== 1'b1 || fu_tid_o !== 2'd0) $display("FAIL arst_issue: fu_req=%b tid=%0d want 1 0", fu_req_o, fu_tid_o); else n_pass++;
      @(negedge clk_i);
      flush_i = '0;
      #1;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL arst_end_idle: busy=%b want 0", busy_o); else n_pass++;
      @(negedge clk_i);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_backpressure();
      test_flush_wait();
      test_flush_race();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
